// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the machine-mode trap sequencer.
//   CSR addresses, mstatus/mie/mip bit positions, mcause codes, FSM states.
package trap_ctrl_pkg;

  localparam int unsigned CoreXlen = 64;
  localparam int unsigned CauseW   = 6;

  localparam logic [11:0] CSRmstatus = 12'h300;
  localparam logic [11:0] CSRmie     = 12'h304;
  localparam logic [11:0] CSRmip     = 12'h344;

  localparam int unsigned MieBit  = 3;
  localparam int unsigned MpieBit = 7;
  localparam int unsigned MppLo   = 11;
  localparam int unsigned MppHi   = 12;
  localparam int unsigned MsiBit  = 3;
  localparam int unsigned MtiBit  = 7;
  localparam int unsigned MeiBit  = 11;

  // Synchronous exception codes (mcause low bits, interrupt bit clear).
  typedef enum logic [CauseW-1:0] {
    CauseInstrMisaligned = 6'd0,
    CauseInstrAccess     = 6'd1,
    CauseIllegalInstr    = 6'd2,
    CauseBreakpoint      = 6'd3,
    CauseLoadMisaligned  = 6'd4,
    CauseLoadAccess      = 6'd5,
    CauseStoreMisaligned = 6'd6,
    CauseStoreAccess     = 6'd7,
    CauseEcallM          = 6'd11
  } csr_mcause_e;

  // Interrupt codes share the low bits with exceptions; the interrupt bit tells them apart.
  localparam logic [CauseW-1:0] CauseIrqMsi = 6'd3;
  localparam logic [CauseW-1:0] CauseIrqMti = 6'd7;
  localparam logic [CauseW-1:0] CauseIrqMei = 6'd11;

  typedef enum logic [1:0] {
    TrapIdle,
    TrapFlush,
    TrapCommit
  } trap_state_e;

  // One bit per machine interrupt source, used for mie, mip and pending.
  typedef struct packed {
    logic mei;
    logic mti;
    logic msi;
  } irq_vec_t;

endpackage

// File: rtl/trap_ctrl_prio_sel.sv
// Combinational trap priority picker.
//   expt_req_i/expt_cause_i : per-stage exception requests, highest index is oldest
//   irq_pend_i              : enabled and pending interrupts
//   expt_*_o                : winning stage index, valid, cause
//   irq_*_o                 : winning interrupt valid and cause (MEI > MSI > MTI)
module trap_ctrl_prio_sel
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned NStages = 3,
  localparam int unsigned IdxW = (NStages > 1) ? $clog2(NStages) : 1
) (
  input  logic [NStages-1:0]             expt_req_i,
  input  logic [NStages-1:0][CauseW-1:0] expt_cause_i,
  input  irq_vec_t                       irq_pend_i,
  output logic                           expt_valid_o,
  output logic [IdxW-1:0]                expt_idx_o,
  output logic [CauseW-1:0]              expt_cause_o,
  output logic                           irq_valid_o,
  output logic [CauseW-1:0]              irq_cause_o
);

  // Later iterations overwrite earlier ones, so the oldest requesting stage wins.
  always_comb begin
    expt_valid_o = 1'b0;
    expt_idx_o   = '0;
    expt_cause_o = '0;
    for (int i = 0; i < int'(NStages); i++) begin
      if (expt_req_i[i]) begin
        expt_valid_o = 1'b1;
        expt_idx_o   = IdxW'(i);
        expt_cause_o = expt_cause_i[i];
      end
    end
  end

  always_comb begin
    irq_valid_o = 1'b1;
    irq_cause_o = CauseIrqMei;
    if (irq_pend_i.mei)      irq_cause_o = CauseIrqMei;
    else if (irq_pend_i.msi) irq_cause_o = CauseIrqMsi;
    else if (irq_pend_i.mti) irq_cause_o = CauseIrqMti;
    else                     irq_valid_o = 1'b0;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions/mret/interrupts, flushes the pipe,
// then issues a one-cycle commit to the CSR file. Owns mstatus.MIE/MPIE, mie, mip.
//   expt_*_i       : per-stage exception requests (highest index oldest)
//   mret_i/retire_*: mret request and interrupt return point
//   irq_*_i        : level interrupt lines
//   csr_*          : CSR access port for mstatus/mie/mip
//   flush_o/flush_done_i : pipeline kill handshake
//   trap_*_o       : commit strobe and payload; busy_o stalls fetch
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned NStages = 3,
  parameter int unsigned Xlen    = CoreXlen
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NStages-1:0]             expt_req_i,
  input  logic [NStages-1:0][CauseW-1:0] expt_cause_i,
  input  logic [NStages-1:0][Xlen-1:0]   expt_value_i,
  input  logic [NStages-1:0][Xlen-1:0]   expt_pc_i,
  input  logic                           mret_i,
  input  logic                           retire_valid_i,
  input  logic [Xlen-1:0]                retire_pc_i,
  input  logic                           irq_sw_i,
  input  logic                           irq_timer_i,
  input  logic                           irq_ext_i,
  input  logic                           csr_we_i,
  input  logic [11:0]                    csr_addr_i,
  input  logic [Xlen-1:0]                csr_wdata_i,
  output logic [Xlen-1:0]                csr_rdata_o,
  output logic                           csr_hit_o,
  output logic                           flush_o,
  input  logic                           flush_done_i,
  output logic                           trap_valid_o,
  output logic                           trap_is_mret_o,
  output logic [Xlen-1:0]                trap_cause_o,
  output logic [Xlen-1:0]                trap_value_o,
  output logic [Xlen-1:0]                trap_pc_o,
  output logic                           busy_o
);

  localparam int unsigned IdxW = (NStages > 1) ? $clog2(NStages) : 1;

  trap_state_e     state_q, state_d;
  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  irq_vec_t        mie_q, mie_d;
  logic            mret_q, mret_d;
  logic [Xlen-1:0] cause_q, cause_d;
  logic [Xlen-1:0] value_q, value_d;
  logic [Xlen-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            busy_q, busy_d;
  logic            trap_valid_q, trap_valid_d;

  irq_vec_t        mip, irq_pend;
  logic            sel_expt_valid, sel_irq_valid;
  logic [IdxW-1:0] sel_expt_idx;
  logic [CauseW-1:0] sel_expt_cause, sel_irq_cause;
  logic            unused_wdata;

  assign unused_wdata = ^csr_wdata_i;

  assign mip      = '{mei: irq_ext_i, mti: irq_timer_i, msi: irq_sw_i};
  assign irq_pend = mip & mie_q & {3{mstatus_mie_q}};

  trap_ctrl_prio_sel #(.NStages(NStages)) u_prio_sel (
    .expt_req_i   (expt_req_i),
    .expt_cause_i (expt_cause_i),
    .irq_pend_i   (irq_pend),
    .expt_valid_o (sel_expt_valid),
    .expt_idx_o   (sel_expt_idx),
    .expt_cause_o (sel_expt_cause),
    .irq_valid_o  (sel_irq_valid),
    .irq_cause_o  (sel_irq_cause)
  );

  // Next-state, capture and CSR update; commit-time MIE/MPIE update overrides a CSR write.
  always_comb begin
    state_d        = state_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mret_d         = mret_q;
    cause_d        = cause_q;
    value_d        = value_q;
    pc_d           = pc_q;

    if (csr_we_i) begin
      if (csr_addr_i == CSRmstatus) begin
        mstatus_mie_d  = csr_wdata_i[MieBit];
        mstatus_mpie_d = csr_wdata_i[MpieBit];
      end else if (csr_addr_i == CSRmie) begin
        mie_d = '{mei: csr_wdata_i[MeiBit], mti: csr_wdata_i[MtiBit], msi: csr_wdata_i[MsiBit]};
      end
    end

    unique case (state_q)
      TrapIdle: begin
        if (sel_expt_valid) begin
          state_d = TrapFlush;
          mret_d  = 1'b0;
          cause_d = '0;
          cause_d[CauseW-1:0] = sel_expt_cause;
          value_d = expt_value_i[sel_expt_idx];
          pc_d    = expt_pc_i[sel_expt_idx];
        end else if (mret_i) begin
          state_d = TrapFlush;
          mret_d  = 1'b1;
          cause_d = '0;
          value_d = '0;
          pc_d    = '0;
        end else if (sel_irq_valid && retire_valid_i) begin
          state_d = TrapFlush;
          mret_d  = 1'b0;
          cause_d = '0;
          cause_d[CauseW-1:0] = sel_irq_cause;
          cause_d[Xlen-1]     = 1'b1;
          value_d = '0;
          pc_d    = retire_pc_i;
        end
      end
      TrapFlush: begin
        if (flush_done_i) state_d = TrapCommit;
      end
      TrapCommit: begin
        state_d = TrapIdle;
        if (mret_q) begin
          mstatus_mie_d  = mstatus_mpie_q;
          mstatus_mpie_d = 1'b1;
        end else begin
          mstatus_mpie_d = mstatus_mie_q;
          mstatus_mie_d  = 1'b0;
        end
      end
      default: state_d = TrapIdle;
    endcase

    flush_d      = (state_d == TrapFlush);
    busy_d       = (state_d != TrapIdle);
    trap_valid_d = (state_d == TrapCommit);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= TrapIdle;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mret_q         <= 1'b0;
      cause_q        <= '0;
      value_q        <= '0;
      pc_q           <= '0;
      flush_q        <= 1'b0;
      busy_q         <= 1'b0;
      trap_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mret_q         <= mret_d;
      cause_q        <= cause_d;
      value_q        <= value_d;
      pc_q           <= pc_d;
      flush_q        <= flush_d;
      busy_q         <= busy_d;
      trap_valid_q   <= trap_valid_d;
    end
  end

  assign flush_o        = flush_q;
  assign busy_o         = busy_q;
  assign trap_valid_o   = trap_valid_q;
  assign trap_is_mret_o = trap_valid_q & mret_q;
  assign trap_cause_o   = trap_valid_q ? cause_q : '0;
  assign trap_value_o   = trap_valid_q ? value_q : '0;
  assign trap_pc_o      = trap_valid_q ? pc_q : '0;

  // CSR read port; MPP is hardwired to machine mode.
  always_comb begin
    csr_rdata_o = '0;
    csr_hit_o   = 1'b1;
    if (csr_addr_i == CSRmstatus) begin
      csr_rdata_o[MppHi:MppLo] = 2'b11;
      csr_rdata_o[MieBit]      = mstatus_mie_q;
      csr_rdata_o[MpieBit]     = mstatus_mpie_q;
    end else if (csr_addr_i == CSRmie) begin
      csr_rdata_o[MeiBit] = mie_q.mei;
      csr_rdata_o[MtiBit] = mie_q.mti;
      csr_rdata_o[MsiBit] = mie_q.msi;
    end else if (csr_addr_i == CSRmip) begin
      csr_rdata_o[MeiBit] = mip.mei;
      csr_rdata_o[MtiBit] = mip.mti;
      csr_rdata_o[MsiBit] = mip.msi;
    end else begin
      csr_hit_o = 1'b0;
    end
  end

endmodule
